// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch unit: PC and IR registers, a one-entry fetch buffer and
// the request/acknowledge handshake to instruction memory.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  input  logic [31:0] JrTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FULL  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JR     = 2'b10;

  fetch_state_t state, state_d;

  logic [31:0] ir, ir_d;
  logic [31:0] fbuf, fbuf_d;
  logic        fbuf_valid, fbuf_valid_d;
  logic        ir_pending, ir_pending_d;
  logic        req_d;
  logic [31:0] addr_d;
  logic        halted_d;
  logic [31:0] pc_d;
  logic [31:0] pc_target;
  logic        pc_upd;
  logic        ir_load;

  assign pc4        = pc + 32'd4;
  assign op         = ir[31:26];
  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign rd         = ir[15:11];
  assign sa         = ir[10:6];
  assign func       = ir[5:0];
  assign imm16      = ir[15:0];
  assign fetch_busy = !fbuf_valid && !halted;

  // Once halted, PC strobes from the control unit have no effect.
  assign pc_upd = PCWre && !halted;

  always_comb begin
    unique case (PCSrc)
      SRC_SEQ:    pc_target = pc4;
      SRC_BRANCH: pc_target = pc4 + (ExtImm << 2);
      SRC_JR:     pc_target = JrTarget & ~32'h0000_0003;
      default:    pc_target = {pc4[31:28], ir[25:0], 2'b00};
    endcase
  end

  assign pc_d = pc_upd ? pc_target : pc;

  // NOTE: every signal assigned below gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    ir_d         = ir;
    ir_load      = 1'b0;
    fbuf_d       = fbuf;
    fbuf_valid_d = fbuf_valid;
    ir_pending_d = ir_pending;
    req_d        = imem_req;
    addr_d       = imem_addr;
    halted_d     = halted;

    unique case (state)
      IDLE: begin
        if (IRWre) ir_pending_d = 1'b1;
        // A PC change here delays the request by one cycle so it uses the new PC.
        if (!pc_upd) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc;
        end
      end

      REQ: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (IRWre || ir_pending) begin
            ir_load      = 1'b1;
            ir_d         = imem_rdata;
            ir_pending_d = 1'b0;
          end
          if (pc_upd) begin
            state_d = IDLE;
          end else begin
            fbuf_d       = imem_rdata;
            fbuf_valid_d = 1'b1;
            state_d      = FULL;
          end
        end else begin
          if (IRWre) ir_pending_d = 1'b1;
          if (pc_upd) state_d = DRAIN;
        end
      end

      FULL: begin
        if (IRWre) begin
          ir_load = 1'b1;
          ir_d    = fbuf;
        end
        if (pc_upd) state_d = IDLE;
      end

      DRAIN: begin
        // The request stays up until memory answers; its data belongs to the old PC.
        if (IRWre) ir_pending_d = 1'b1;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      HALT: begin
        req_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (pc_upd) fbuf_valid_d = 1'b0;

    if (ir_load && (ir_d[31:26] == HALT_OP)) begin
      state_d      = HALT;
      req_d        = 1'b0;
      halted_d     = 1'b1;
      ir_pending_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      ir         <= '0;
      fbuf       <= '0;
      fbuf_valid <= 1'b0;
      ir_pending <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= PC_RESET;
      halted     <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      ir         <= ir_d;
      fbuf       <= fbuf_d;
      fbuf_valid <= fbuf_valid_d;
      ir_pending <= ir_pending_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
      halted     <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a wait-state
// programmable instruction memory responder.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCWre, IRWre;
  logic [1:0]  PCSrc;
  logic [31:0] ExtImm, JrTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  logic [31:0] pc, pc4;
  logic        fetch_busy, halted;

  int checks = 0;
  int errors = 0;
  int mem_wait = 0;

  instr_fetch_unit dut (
    .CLK        (CLK),
    .RST        (RST),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .PCSrc      (PCSrc),
    .ExtImm     (ExtImm),
    .JrTarget   (JrTarget),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .op         (op),
    .func       (func),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .sa         (sa),
    .imm16      (imm16),
    .pc         (pc),
    .pc4        (pc4),
    .fetch_busy (fetch_busy),
    .halted     (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2008_0005;
      32'h0000_0004: return 32'h0800_0010;
      32'h0000_0100: return 32'hFC00_0000;
      default:       return addr;
    endcase
  endfunction

  // Memory responder: acks after mem_wait extra cycles of a held request.
  initial begin
    int cnt;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge CLK);
      imem_ack = 1'b0;
      if (imem_req && RST) begin
        if (cnt == mem_wait) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Drives strobes for exactly one cycle; returns at the following negedge.
  task automatic strobe(input logic pcw, input logic irw, input logic [1:0] src,
                        input logic [31:0] ext, input logic [31:0] jr);
    PCWre = pcw;
    IRWre = irw;
    PCSrc = src;
    ExtImm = ext;
    JrTarget = jr;
    @(negedge CLK);
    PCWre = 1'b0;
    IRWre = 1'b0;
  endtask

  task automatic wait_full(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!fetch_busy) break;
    end
    check(tag, 32'(fetch_busy), 32'd0);
  endtask

  initial begin
    int held;
    logic addr_stable;
    RST = 1'b0;
    PCWre = 1'b0;
    IRWre = 1'b0;
    PCSrc = 2'b00;
    ExtImm = '0;
    JrTarget = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_pc", pc, 32'h0);
    check("rst_op", 32'(op), 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    RST = 1'b1;

    // First fetch, zero-wait memory
    @(negedge CLK);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_busy", 32'(fetch_busy), 32'd1);
    @(negedge CLK);
    check("first_valid", 32'(fetch_busy), 32'd0);
    check("first_req_drop", 32'(imem_req), 32'd0);
    strobe(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    check("ir0_op", 32'(op), 32'h08);
    check("ir0_rs", 32'(rs), 32'd0);
    check("ir0_rt", 32'(rt), 32'd8);
    check("ir0_imm", 32'(imm16), 32'd5);

    // Sequential fetch with three wait states and a deferred IR load
    mem_wait = 3;
    strobe(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("seq_pc", pc, 32'h4);
    check("seq_pc4", pc4, 32'h8);
    check("seq_idle_req", 32'(imem_req), 32'd0);
    check("seq_busy", 32'(fetch_busy), 32'd1);
    @(negedge CLK);
    IRWre = 1'b1;
    held = 0;
    addr_stable = 1'b1;
    while (imem_req && held < 20) begin
      held++;
      if (imem_addr !== 32'h4) addr_stable = 1'b0;
      @(negedge CLK);
      IRWre = 1'b0;
    end
    check("ws_req_cycles", 32'(held), 32'd4);
    check("ws_addr_stable", 32'(addr_stable), 32'd1);
    check("ws_valid", 32'(fetch_busy), 32'd0);
    check("deferred_op", 32'(op), 32'h02);
    check("deferred_imm", 32'(imm16), 32'h0010);
    mem_wait = 0;

    // Branch backward then forward
    strobe(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    check("to8_pc", pc, 32'h8);
    wait_full("to8_fill");
    strobe(1'b1, 1'b0, 2'b01, 32'hFFFF_FFFE, 32'h0);
    check("br_back_pc", pc, 32'h4);
    wait_full("br_back_fill");
    strobe(1'b1, 1'b0, 2'b01, 32'h0000_0003, 32'h0);
    check("br_fwd_pc", pc, 32'd20);
    wait_full("br_fwd_fill");

    // j uses IR = 0x0800_0010, then jr with unaligned target
    strobe(1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    check("j_pc", pc, 32'h40);
    wait_full("j_fill");
    strobe(1'b1, 1'b0, 2'b10, 32'h0, 32'h123);
    check("jr_pc", pc, 32'h120);
    @(negedge CLK);
    check("jr_fetch_addr", imem_addr, 32'h120);
    @(negedge CLK);

    // PCWre and IRWre together: IR takes the old buffer, PC advances
    strobe(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
    check("same_imm", 32'(imm16), 32'h0120);
    check("same_pc", pc, 32'h124);

    // PC change while a request is outstanding
    mem_wait = 2;
    @(negedge CLK);
    check("drain_req_on", 32'(imem_req), 32'd1);
    strobe(1'b1, 1'b0, 2'b10, 32'h0, 32'h200);
    check("drain_pc", pc, 32'h200);
    check("drain_req_held", 32'(imem_req), 32'd1);
    check("drain_addr_held", imem_addr, 32'h124);
    @(negedge CLK);
    @(negedge CLK);
    check("drain_done_req", 32'(imem_req), 32'd0);
    check("drain_discard", 32'(fetch_busy), 32'd1);
    check("drain_ir_kept", 32'(imm16), 32'h0120);
    @(negedge CLK);
    check("drain_refetch_addr", imem_addr, 32'h200);
    wait_full("drain_fill");
    mem_wait = 0;
    strobe(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    check("drain_new_ir", 32'(imm16), 32'h0200);

    // Halt loaded through the ack-cycle bypass
    strobe(1'b1, 1'b0, 2'b10, 32'h0, 32'h100);
    check("halt_pc", pc, 32'h100);
    IRWre = 1'b1;
    @(negedge CLK);
    check("bypass_ack_cycle_req", 32'(imem_req), 32'd1);
    @(negedge CLK);
    IRWre = 1'b0;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_op", 32'(op), 32'h3F);
    check("halt_req", 32'(imem_req), 32'd0);
    strobe(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    strobe(1'b1, 1'b0, 2'b01, 32'h5, 32'h0);
    check("halt_pc_frozen", pc, 32'h100);
    check("halt_no_req", 32'(imem_req), 32'd0);
    check("halt_not_busy", 32'(fetch_busy), 32'd0);

    // Asynchronous reset clears the halt without a clock edge
    #2;
    RST = 1'b0;
    #1;
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_busy", 32'(fetch_busy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
